// File: rtl/vga_pixel_arbiter.sv
// Pixel-write arbiter for the VGA adapter: clears the frame buffer after reset,
// then forwards round-robin bursts from two sprite clients as registered writes.
module vga_pixel_arbiter #(
    parameter int         BURST        = 32,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'd0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [2:0] c0,
    input  logic [2:0] c1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       plot,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       busy
);

    localparam int            BW        = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
    localparam logic [7:0]    X_LIM     = 8'(SCREEN_W);
    localparam logic [7:0]    X_LAST    = 8'(SCREEN_W - 1);
    localparam logic [6:0]    Y_LIM     = 7'(SCREEN_H);
    localparam logic [6:0]    Y_LAST    = 7'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SERVE0,
        SERVE1
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    cx, cx_nxt;
    logic [6:0]    cy, cy_nxt;
    logic [BW-1:0] beat, beat_nxt;
    logic          last, last_nxt;
    logic          plot_nxt, done0_nxt, done1_nxt;
    logic [7:0]    x_nxt;
    logic [6:0]    y_nxt;
    logic [2:0]    colour_nxt;

    logic          sel;
    logic          req_s;
    logic [7:0]    x_s;
    logic [6:0]    y_s;
    logic [2:0]    c_s;

    // Both SERVE states share one datapath; sel picks the client being served.
    assign sel   = (state == SERVE1);
    assign req_s = sel ? req1 : req0;
    assign x_s   = sel ? x1 : x0;
    assign y_s   = sel ? y1 : y0;
    assign c_s   = sel ? c1 : c0;

    assign gnt0 = (state == SERVE0);
    assign gnt1 = (state == SERVE1);
    assign busy = (state == CLEAR);

    always_comb begin
        state_nxt  = state;
        cx_nxt     = cx;
        cy_nxt     = cy;
        beat_nxt   = beat;
        last_nxt   = last;
        plot_nxt   = 1'b0;
        x_nxt      = x;
        y_nxt      = y;
        colour_nxt = colour;
        done0_nxt  = 1'b0;
        done1_nxt  = 1'b0;

        case (state)
            CLEAR: begin
                plot_nxt   = 1'b1;
                x_nxt      = cx;
                y_nxt      = cy;
                colour_nxt = CLEAR_COLOUR;
                if (cx == X_LAST) begin
                    cx_nxt = '0;
                    if (cy == Y_LAST) begin
                        cy_nxt    = '0;
                        state_nxt = IDLE;
                    end else begin
                        cy_nxt = cy + 7'd1;
                    end
                end else begin
                    cx_nxt = cx + 8'd1;
                end
            end

            IDLE: begin
                beat_nxt = '0;
                // On a tie, last==1 means client 1 was served last, so client 0 wins.
                if (req0 && (!req1 || last)) begin
                    state_nxt = SERVE0;
                end else if (req1) begin
                    state_nxt = SERVE1;
                end
            end

            SERVE0, SERVE1: begin
                if (!req_s) begin
                    state_nxt = IDLE;
                    last_nxt  = sel;
                end else begin
                    x_nxt      = x_s;
                    y_nxt      = y_s;
                    colour_nxt = c_s;
                    plot_nxt   = (x_s < X_LIM) && (y_s < Y_LIM);
                    beat_nxt   = beat + BW'(1);
                    if (beat == BEAT_LAST) begin
                        state_nxt = IDLE;
                        last_nxt  = sel;
                        done0_nxt = !sel;
                        done1_nxt = sel;
                    end
                end
            end

            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= CLEAR;
            cx     <= '0;
            cy     <= '0;
            beat   <= '0;
            last   <= 1'b1;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            done0  <= 1'b0;
            done1  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cx     <= cx_nxt;
            cy     <= cy_nxt;
            beat   <= beat_nxt;
            last   <= last_nxt;
            plot   <= plot_nxt;
            x      <= x_nxt;
            y      <= y_nxt;
            colour <= colour_nxt;
            done0  <= done0_nxt;
            done1  <= done1_nxt;
        end
    end

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// Directed bench for vga_pixel_arbiter: clear sweep, bursts, round robin,
// off-screen suppression, abort and reset mid-burst.
module tb_vga_pixel_arbiter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req0, req1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] c0, c1;
    logic       gnt0, gnt1, done0, done1, plot, busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int n_cmp = 0;
    int n_err = 0;
    int burst_plots;

    typedef struct {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
        logic       exp_plot;
    } vec_t;

    vec_t cur0[32], cur1[32];
    vec_t single_vec[32], off_vec[32], rr0_vec[32], rr1_vec[32];

    always #5 clock = ~clock;

    vga_pixel_arbiter dut (
        .clock (clock),
        .resetn(resetn),
        .req0  (req0),
        .req1  (req1),
        .x0    (x0),
        .x1    (x1),
        .y0    (y0),
        .y1    (y1),
        .c0    (c0),
        .c1    (c1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done0 (done0),
        .done1 (done1),
        .plot  (plot),
        .x     (x),
        .y     (y),
        .colour(colour),
        .busy  (busy)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, act, want);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    function automatic logic gnt_of(input int c);
        return (c == 1) ? gnt1 : gnt0;
    endfunction

    function automatic logic done_of(input int c);
        return (c == 1) ? done1 : done0;
    endfunction

    task automatic set_req(input int c, input logic v);
        if (c == 0) req0 = v;
        else        req1 = v;
    endtask

    task automatic drive_client(input int c, input vec_t v);
        if (c == 0) begin
            x0 = v.px; y0 = v.py; c0 = v.pc;
        end else begin
            x1 = v.px; y1 = v.py; c1 = v.pc;
        end
    endtask

    // Values on the non-granted client's pins must never reach the outputs.
    task automatic drive_junk(input int c);
        if (c == 0) begin
            x0 = 8'hAA; y0 = 7'h55; c0 = 3'd7;
        end else begin
            x1 = 8'h33; y1 = 7'h2A; c1 = 3'd5;
        end
    endtask

    task automatic compare_pixel(input int c, input int k);
        vec_t p;
        p = (c == 0) ? cur0[k] : cur1[k];
        check_output($sformatf("c%0d pix%0d plot", c, k), 32'(plot), 32'(p.exp_plot));
        check_output($sformatf("c%0d pix%0d x", c, k), 32'(x), 32'(p.px));
        check_output($sformatf("c%0d pix%0d y", c, k), 32'(y), 32'(p.py));
        check_output($sformatf("c%0d pix%0d colour", c, k), 32'(colour), 32'(p.pc));
        if (plot) burst_plots++;
    endtask

    // Entered at the negedge of gnt cycle 0; returns at the negedge of the
    // done cycle (or the abort cycle when drop_at < 32).
    task automatic apply_stimulus(input int c, input int drop_at, input bit drop_at_done);
        vec_t v;
        burst_plots = 0;
        for (int k = 0; k < 32; k++) begin
            check_output($sformatf("c%0d beat%0d gnt", c, k), 32'(gnt_of(c)), 1);
            check_output($sformatf("c%0d beat%0d other gnt", c, k), 32'(gnt_of(1 - c)), 0);
            if (k == 0) check_output("done at grant start", 32'({done0, done1}), 0);
            if (k > 0) compare_pixel(c, k - 1);
            if (k == drop_at) begin
                set_req(c, 1'b0);
                drive_junk(c);
                step();
                check_output("abort gnt", 32'(gnt_of(c)), 0);
                check_output("abort plot", 32'(plot), 0);
                check_output("abort done", 32'(done_of(c)), 0);
                return;
            end
            v = (c == 0) ? cur0[k] : cur1[k];
            drive_client(c, v);
            drive_junk(1 - c);
            step();
        end
        check_output("gnt0 after burst", 32'(gnt0), 0);
        check_output("gnt1 after burst", 32'(gnt1), 0);
        compare_pixel(c, 31);
        check_output($sformatf("c%0d done", c), 32'(done_of(c)), 1);
        check_output($sformatf("c%0d other done", c), 32'(done_of(1 - c)), 0);
        if (drop_at_done) set_req(c, 1'b0);
    endtask

    task automatic wait_any_gnt(output int which, output int steps);
        which = -1;
        steps = 0;
        for (int i = 1; i <= 40 && which < 0; i++) begin
            step();
            if (gnt0) begin
                which = 0; steps = i;
            end else if (gnt1) begin
                which = 1; steps = i;
            end
        end
    endtask

    initial begin
        int which, steps, plots, first_cycle, bad_xy, bad_col, gnt_early, busy_first, ex, ey;
        logic [7:0] last_x;
        logic [6:0] last_y;

        for (int k = 0; k < 32; k++) begin
            single_vec[k].px       = (k < 16) ? 8'd60 : 8'd61;
            single_vec[k].py       = 7'(k % 16);
            single_vec[k].pc       = 3'(k + 1);
            single_vec[k].exp_plot = 1'b1;
            if (k < 16) begin
                off_vec[k].px       = 8'd159;
                off_vec[k].py       = 7'(110 + k);
                off_vec[k].exp_plot = (110 + k) < 120;
            end else begin
                off_vec[k].px       = 8'(152 + k - 16);
                off_vec[k].py       = 7'd5;
                off_vec[k].exp_plot = (152 + k - 16) < 160;
            end
            off_vec[k].pc         = 3'(k);
            rr0_vec[k].px         = 8'(4 * k);
            rr0_vec[k].py         = 7'(3 * k);
            rr0_vec[k].pc         = 3'(k);
            rr0_vec[k].exp_plot   = 1'b1;
            rr1_vec[k].px         = 8'(100 + k);
            rr1_vec[k].py         = 7'(119 - k);
            rr1_vec[k].pc         = 3'(7 - k);
            rr1_vec[k].exp_plot   = 1'b1;
        end

        resetn = 1'b0;
        req0 = 1'b1; req1 = 1'b0;
        x0 = '0; y0 = '0; c0 = '0; x1 = '0; y1 = '0; c1 = '0;
        repeat (3) step();
        check_output("reset plot", 32'(plot), 0);
        check_output("reset x", 32'(x), 0);
        check_output("reset y", 32'(y), 0);
        check_output("reset colour", 32'(colour), 0);
        check_output("reset gnt", 32'({gnt0, gnt1}), 0);
        check_output("reset done", 32'({done0, done1}), 0);
        check_output("reset busy", 32'(busy), 1);

        // Clear sweep with req0 held high the whole time.
        resetn = 1'b1;
        plots = 0; first_cycle = -1; bad_xy = 0; bad_col = 0; gnt_early = 0;
        busy_first = -1; ex = 0; ey = 0; last_x = '0; last_y = '0;
        for (int i = 0; i < 20000; i++) begin
            step();
            if (plot) begin
                if (plots == 0) begin
                    first_cycle = i;
                    busy_first  = int'(busy);
                end
                if (x != 8'(ex) || y != 7'(ey)) bad_xy++;
                if (colour != 3'd0) bad_col++;
                if (gnt0 || gnt1) gnt_early++;
                last_x = x; last_y = y;
                plots++;
                ex++;
                if (ex == 160) begin
                    ex = 0; ey++;
                end
            end else if (plots > 0) begin
                break;
            end else if (gnt0 || gnt1) begin
                gnt_early++;
            end
        end
        check_output("clear plot count", plots, 19200);
        check_output("clear first cycle", first_cycle, 0);
        check_output("clear busy at start", busy_first, 1);
        check_output("clear xy order errors", bad_xy, 0);
        check_output("clear colour errors", bad_col, 0);
        check_output("clear last x", 32'(last_x), 159);
        check_output("clear last y", 32'(last_y), 119);
        check_output("gnt during clear", gnt_early, 0);
        check_output("busy after clear", 32'(busy), 0);

        // Single burst from client 0: granted as soon as the clear ends.
        cur0 = single_vec;
        cur1 = rr1_vec;
        apply_stimulus(0, 32, 1'b1);
        check_output("single burst plots", burst_plots, 32);

        // Off-screen suppression on client 1.
        req1 = 1'b1;
        cur1 = off_vec;
        wait_any_gnt(which, steps);
        check_output("offscreen grant", which, 1);
        check_output("offscreen grant latency", steps, 1);
        apply_stimulus(1, 32, 1'b1);
        check_output("offscreen plots", burst_plots, 18);
        step();
        check_output("idle plot", 32'(plot), 0);
        check_output("idle gnt", 32'({gnt0, gnt1}), 0);

        // Round robin with both requests held.
        cur0 = rr0_vec;
        cur1 = rr1_vec;
        req0 = 1'b1; req1 = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wait_any_gnt(which, steps);
            check_output($sformatf("rr burst%0d client", b), which, b % 2);
            check_output($sformatf("rr burst%0d gap", b), steps, 1);
            apply_stimulus(b % 2, 32, b == 3);
            check_output($sformatf("rr burst%0d plots", b), burst_plots, 32);
        end
        req0 = 1'b0;
        step();
        check_output("rr idle plot", 32'(plot), 0);
        check_output("rr idle gnt", 32'({gnt0, gnt1}), 0);

        // Abort at beat 10 with client 1 pending.
        req0 = 1'b1; req1 = 1'b1;
        wait_any_gnt(which, steps);
        check_output("abort tie winner", which, 0);
        apply_stimulus(0, 10, 1'b0);
        check_output("abort plots", burst_plots, 10);
        wait_any_gnt(which, steps);
        check_output("pending grant client", which, 1);
        check_output("pending grant gap", steps, 1);

        // Reset at beat 5 of the SERVE1 burst.
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("pre-reset beat%0d gnt1", k), 32'(gnt1), 1);
            drive_client(1, cur1[k]);
            step();
        end
        resetn = 1'b0;
        #1;
        check_output("mid reset gnt1", 32'(gnt1), 0);
        check_output("mid reset plot", 32'(plot), 0);
        check_output("mid reset busy", 32'(busy), 1);
        req1 = 1'b0;
        step();
        resetn = 1'b1;
        step();
        check_output("reclear plot", 32'(plot), 1);
        check_output("reclear x0", 32'(x), 0);
        check_output("reclear y0", 32'(y), 0);
        check_output("reclear busy", 32'(busy), 1);
        step();
        check_output("reclear x1", 32'(x), 1);
        check_output("reclear y1", 32'(y), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
